// File: rtl/ras_pkg.sv
// Shared constants, request encoding and request decode for the RAS/chip-select generator.
package ras_pkg;

  localparam int RAS_NBANK = 4;
  localparam int RAS_TRAS  = 3;
  localparam int RAS_TRP   = 2;
  localparam int RAS_CW    = 4;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_OPEN,
    REQ_CLOSE
  } ras_req_t;

  // A toggle resolves against the current chip-select state: open banks close, closed banks open.
  function automatic ras_req_t ras_decode(input logic set, input logic clr, input logic cs);
    ras_req_t req;
    req = REQ_NONE;
    if (set && !clr) begin
      req = REQ_OPEN;
    end else if (clr && !set) begin
      req = REQ_CLOSE;
    end else if (set && clr) begin
      req = cs ? REQ_CLOSE : REQ_OPEN;
    end
    return req;
  endfunction

endpackage

// File: rtl/ras_bank.sv
// One bank of the RAS/chip-select generator: JK-style cs flop, plus tRAS/tRP guard
// counter and pending flags when RASGEN_TIMING_EN is defined.
module ras_bank
  import ras_pkg::*;
`ifdef RASGEN_TIMING_EN
#(
  parameter int TRAS = RAS_TRAS,
  parameter int TRP  = RAS_TRP,
  parameter int CW   = RAS_CW
)
`endif
(
  input  logic clk,
  input  logic resl,
  input  logic bs,
  input  logic on1,
  input  logic roffl,
  input  logic allonl,
  input  logic alloffl,
  output logic csl,
  output logic busy
);

  logic     cs;
  logic     set;
  logic     clr;
  ras_req_t req;

  assign set = (bs & on1) | ~allonl;
  assign clr = ~roffl | ~alloffl;
  assign req = ras_decode(set, clr, cs);

  assign csl = ~cs;

`ifdef RASGEN_TIMING_EN

  localparam logic [CW-1:0] TRAS_LOAD = CW'(TRAS - 1);
  localparam logic [CW-1:0] TRP_LOAD  = CW'(TRP - 1);

  logic [CW-1:0] cnt;
  logic          cnt_zero;
  logic          pend_open;
  logic          pend_close;

  assign cnt_zero = (cnt == '0);
  assign busy     = ~cnt_zero | pend_open | pend_close;

  // A request that arrives while the guard counter runs is parked; the opposite request unparks it.
  always_ff @(posedge clk or negedge resl) begin
    if (!resl) begin
      cs         <= 1'b0;
      cnt        <= '0;
      pend_open  <= 1'b0;
      pend_close <= 1'b0;
    end else begin
      if (!cnt_zero) begin
        cnt <= cnt - CW'(1);
      end
      case (req)
        REQ_OPEN: begin
          pend_close <= 1'b0;
          if (!cs) begin
            if (cnt_zero) begin
              cs        <= 1'b1;
              cnt       <= TRAS_LOAD;
              pend_open <= 1'b0;
            end else begin
              pend_open <= 1'b1;
            end
          end
        end
        REQ_CLOSE: begin
          pend_open <= 1'b0;
          if (cs) begin
            if (cnt_zero) begin
              cs         <= 1'b0;
              cnt        <= TRP_LOAD;
              pend_close <= 1'b0;
            end else begin
              pend_close <= 1'b1;
            end
          end
        end
        default: begin
          if (!cs && pend_open && cnt_zero) begin
            cs        <= 1'b1;
            cnt       <= TRAS_LOAD;
            pend_open <= 1'b0;
          end else if (cs && pend_close && cnt_zero) begin
            cs         <= 1'b0;
            cnt        <= TRP_LOAD;
            pend_close <= 1'b0;
          end
        end
      endcase
    end
  end

`else

  assign busy = 1'b0;

  always_ff @(posedge clk or negedge resl) begin
    if (!resl) begin
      cs <= 1'b0;
    end else begin
      case (req)
        REQ_OPEN:  cs <= 1'b1;
        REQ_CLOSE: cs <= 1'b0;
        default:   cs <= cs;
      endcase
    end
  end

`endif

endmodule

// File: rtl/ras_bank_gen.sv
// Multi-bank RAS/chip-select generator; one ras_bank per chip select, global requests fanned out.
// Timing guards (tRAS/tRP) are built only when RASGEN_TIMING_EN is defined.
module ras_bank_gen
  import ras_pkg::*;
#(
  parameter int NBANK = RAS_NBANK
`ifdef RASGEN_TIMING_EN
  ,
  parameter int TRAS  = RAS_TRAS,
  parameter int TRP   = RAS_TRP,
  parameter int CW    = RAS_CW
`endif
) (
  input  logic             clk,
  input  logic             resl,
  input  logic [NBANK-1:0] bs,
  input  logic             on1,
  input  logic [NBANK-1:0] roffl,
  input  logic             allonl,
  input  logic             alloffl,
  output logic [NBANK-1:0] csl,
  output logic [NBANK-1:0] busy
);

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    ras_bank
`ifdef RASGEN_TIMING_EN
      #(
        .TRAS (TRAS),
        .TRP  (TRP),
        .CW   (CW)
      )
`endif
      u_bank (
        .clk     (clk),
        .resl    (resl),
        .bs      (bs[b]),
        .on1     (on1),
        .roffl   (roffl[b]),
        .allonl  (allonl),
        .alloffl (alloffl),
        .csl     (csl[b]),
        .busy    (busy[b])
      );
  end

endmodule

// File: tb/tb_ras_bank_gen.sv
// Directed bench for ras_bank_gen (NBANK=4, TRAS=3, TRP=2); expectations follow RASGEN_TIMING_EN.
module tb_ras_bank_gen;

  logic       clk;
  logic       resl;
  logic [3:0] bs;
  logic       on1;
  logic [3:0] roffl;
  logic       allonl;
  logic       alloffl;
  logic [3:0] csl;
  logic [3:0] busy;

  int vec_count;
  int miss_count;

  ras_bank_gen dut (
    .clk     (clk),
    .resl    (resl),
    .bs      (bs),
    .on1     (on1),
    .roffl   (roffl),
    .allonl  (allonl),
    .alloffl (alloffl),
    .csl     (csl),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one set of request inputs, let one rising edge sample them, then settle 1 time unit.
  task automatic applyStimulus(input logic [3:0] b, input logic o, input logic [3:0] r,
                               input logic an, input logic af);
    bs      = b;
    on1     = o;
    roffl   = r;
    allonl  = an;
    alloffl = af;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(4'b0000, 1'b0, 4'b1111, 1'b1, 1'b1);
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] exp_csl, input logic [3:0] exp_busy);
    vec_count++;
    assert (csl === exp_csl) else begin
      miss_count++;
      $error("[TB] FAIL %s csl got %b want %b", tag, csl, exp_csl);
    end
    vec_count++;
    assert (busy === exp_busy) else begin
      miss_count++;
      $error("[TB] FAIL %s busy got %b want %b", tag, busy, exp_busy);
    end
  endtask

  initial begin
    vec_count  = 0;
    miss_count = 0;
    resl       = 1'b0;
    bs         = 4'b0000;
    on1        = 1'b0;
    roffl      = 4'b1111;
    allonl     = 1'b1;
    alloffl    = 1'b1;

    #12;
    checkOutput("in_reset", 4'b1111, 4'b0000);
    resl = 1'b1;
    idle();
    checkOutput("idle_a", 4'b1111, 4'b0000);
    idle();
    checkOutput("idle_b", 4'b1111, 4'b0000);

`ifdef RASGEN_TIMING_EN
    // Bank 0: open, early close is deferred until tRAS expires.
    applyStimulus(4'b0001, 1'b1, 4'b1111, 1'b1, 1'b1);
    checkOutput("b0_open", 4'b1110, 4'b0001);
    applyStimulus(4'b0000, 1'b0, 4'b1110, 1'b1, 1'b1);
    checkOutput("b0_pend_close", 4'b1110, 4'b0001);
    idle();
    checkOutput("b0_hold", 4'b1110, 4'b0001);
    idle();
    checkOutput("b0_closed", 4'b1111, 4'b0001);
    idle();
    checkOutput("b0_trp_done", 4'b1111, 4'b0000);

    // Bank 2: open, let tRAS run out, close, then an early reopen is deferred by tRP.
    applyStimulus(4'b0100, 1'b1, 4'b1111, 1'b1, 1'b1);
    checkOutput("b2_open", 4'b1011, 4'b0100);
    idle();
    idle();
    checkOutput("b2_tras_done", 4'b1011, 4'b0000);
    applyStimulus(4'b0000, 1'b0, 4'b1011, 1'b1, 1'b1);
    checkOutput("b2_close", 4'b1111, 4'b0100);
    applyStimulus(4'b0100, 1'b1, 4'b1111, 1'b1, 1'b1);
    checkOutput("b2_pend_open", 4'b1111, 4'b0100);
    idle();
    checkOutput("b2_reopen", 4'b1011, 4'b0100);
    idle();
    idle();
    applyStimulus(4'b0000, 1'b0, 4'b1011, 1'b1, 1'b1);
    checkOutput("b2_close2", 4'b1111, 4'b0100);
    idle();
    checkOutput("b2_idle", 4'b1111, 4'b0000);

    // Bank 3: a pending close is cancelled by a later open; bank stays open.
    applyStimulus(4'b1000, 1'b1, 4'b1111, 1'b1, 1'b1);
    checkOutput("b3_open", 4'b0111, 4'b1000);
    applyStimulus(4'b0000, 1'b0, 4'b0111, 1'b1, 1'b1);
    checkOutput("b3_pend_close", 4'b0111, 4'b1000);
    applyStimulus(4'b1000, 1'b1, 4'b1111, 1'b1, 1'b1);
    checkOutput("b3_cancel", 4'b0111, 4'b0000);
    idle();
    checkOutput("b3_still_open", 4'b0111, 4'b0000);
    applyStimulus(4'b0000, 1'b0, 4'b0111, 1'b1, 1'b1);
    checkOutput("b3_close", 4'b1111, 4'b1000);
    idle();
    checkOutput("b3_idle", 4'b1111, 4'b0000);

    // Global all-on, then all-off three edges later.
    applyStimulus(4'b0000, 1'b0, 4'b1111, 1'b0, 1'b1);
    checkOutput("all_on", 4'b0000, 4'b1111);
    idle();
    checkOutput("all_on_cnt1", 4'b0000, 4'b1111);
    idle();
    checkOutput("all_on_cnt0", 4'b0000, 4'b0000);
    applyStimulus(4'b0000, 1'b0, 4'b1111, 1'b1, 1'b0);
    checkOutput("all_off", 4'b1111, 4'b1111);
    idle();
    checkOutput("all_off_idle", 4'b1111, 4'b0000);

    // Bank 2 toggle held 8 cycles: 3 cycles low, 2 high, repeating.
    applyStimulus(4'b0100, 1'b1, 4'b1011, 1'b1, 1'b1);
    checkOutput("tgl_0", 4'b1011, 4'b0100);
    applyStimulus(4'b0100, 1'b1, 4'b1011, 1'b1, 1'b1);
    checkOutput("tgl_1", 4'b1011, 4'b0100);
    applyStimulus(4'b0100, 1'b1, 4'b1011, 1'b1, 1'b1);
    checkOutput("tgl_2", 4'b1011, 4'b0100);
    applyStimulus(4'b0100, 1'b1, 4'b1011, 1'b1, 1'b1);
    checkOutput("tgl_3", 4'b1111, 4'b0100);
    applyStimulus(4'b0100, 1'b1, 4'b1011, 1'b1, 1'b1);
    checkOutput("tgl_4", 4'b1111, 4'b0100);
    applyStimulus(4'b0100, 1'b1, 4'b1011, 1'b1, 1'b1);
    checkOutput("tgl_5", 4'b1011, 4'b0100);
    applyStimulus(4'b0100, 1'b1, 4'b1011, 1'b1, 1'b1);
    checkOutput("tgl_6", 4'b1011, 4'b0100);
    applyStimulus(4'b0100, 1'b1, 4'b1011, 1'b1, 1'b1);
    checkOutput("tgl_7", 4'b1011, 4'b0100);
    idle();
    checkOutput("tgl_pend_exec", 4'b1111, 4'b0100);
    idle();
    checkOutput("tgl_idle", 4'b1111, 4'b0000);

    // Bank 1 open with a pending close, then reset mid-cycle.
    applyStimulus(4'b0010, 1'b1, 4'b1111, 1'b1, 1'b1);
    checkOutput("b1_open", 4'b1101, 4'b0010);
    applyStimulus(4'b0000, 1'b0, 4'b1101, 1'b1, 1'b1);
    checkOutput("b1_pend_close", 4'b1101, 4'b0010);
`else
    // Plain JK behaviour: every request acts at the next edge, busy never asserts.
    applyStimulus(4'b0001, 1'b1, 4'b1111, 1'b1, 1'b1);
    checkOutput("b0_open", 4'b1110, 4'b0000);
    applyStimulus(4'b0000, 1'b0, 4'b1110, 1'b1, 1'b1);
    checkOutput("b0_close", 4'b1111, 4'b0000);
    applyStimulus(4'b1000, 1'b1, 4'b1111, 1'b1, 1'b1);
    checkOutput("b3_open", 4'b0111, 4'b0000);
    applyStimulus(4'b1000, 1'b1, 4'b1111, 1'b1, 1'b1);
    checkOutput("b3_open_again", 4'b0111, 4'b0000);
    applyStimulus(4'b0000, 1'b0, 4'b0111, 1'b1, 1'b1);
    checkOutput("b3_close", 4'b1111, 4'b0000);
    applyStimulus(4'b0000, 1'b0, 4'b1111, 1'b0, 1'b1);
    checkOutput("all_on", 4'b0000, 4'b0000);
    idle();
    checkOutput("all_on_hold", 4'b0000, 4'b0000);
    applyStimulus(4'b0000, 1'b0, 4'b1111, 1'b1, 1'b0);
    checkOutput("all_off", 4'b1111, 4'b0000);
    applyStimulus(4'b0100, 1'b1, 4'b1011, 1'b1, 1'b1);
    checkOutput("tgl_0", 4'b1011, 4'b0000);
    applyStimulus(4'b0100, 1'b1, 4'b1011, 1'b1, 1'b1);
    checkOutput("tgl_1", 4'b1111, 4'b0000);
    applyStimulus(4'b0100, 1'b1, 4'b1011, 1'b1, 1'b1);
    checkOutput("tgl_2", 4'b1011, 4'b0000);
    applyStimulus(4'b0100, 1'b1, 4'b1011, 1'b1, 1'b1);
    checkOutput("tgl_3", 4'b1111, 4'b0000);
    applyStimulus(4'b0010, 1'b1, 4'b1111, 1'b1, 1'b1);
    checkOutput("b1_open", 4'b1101, 4'b0000);
`endif

    // Asynchronous reset away from the clock edge.
    #2;
    resl = 1'b0;
    #1;
    checkOutput("async_reset", 4'b1111, 4'b0000);
    bs      = 4'b0000;
    on1     = 1'b0;
    roffl   = 4'b1111;
    allonl  = 1'b1;
    alloffl = 1'b1;
    #2;
    resl = 1'b1;
    idle();
    checkOutput("post_reset", 4'b1111, 4'b0000);
    idle();
    checkOutput("post_reset_idle", 4'b1111, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule

// File: doc/ras_bank_gen.md
# ras_bank_gen

Parametrised multi-bank RAS/chip-select generator for the memory controller. Each bank holds a JK-style chip-select flop: set by a bank-selected open or a global all-on, cleared by a per-bank close or a global all-off, toggled when both act together. Unlike the single-bank generator, it enforces minimum active time (tRAS) and minimum precharge time (tRP) per bank, deferring requests that arrive too early. It sits between the memory sequencer and the DRAM RAS/CS pins.

## Interface

- NBANK, 4: number of banks / chip selects, 1..8
- TRAS, 3: minimum cycles a bank stays open, >=1
- TRP, 2: minimum cycles a bank stays closed, >=1
- CW, 4: timing counter width; must hold max(TRAS,TRP)-1

Clock is `clk`; reset `resl` is asynchronous, active-low.

- clk  in  1  system clock, all state on rising edge
- resl  in  1  asynchronous active-low reset
- bs  in  NBANK  bank select, one-hot or zero
- on1  in  1  open request for banks selected by `bs`
- roffl  in  NBANK  per-bank close request, active-low
- allonl  in  1  open all banks, active-low (refresh)
- alloffl  in  1  close all banks, active-low
- csl  out  NBANK  chip select per bank, active-low, registered
- busy  out  NBANK  bank has a timing counter running or a request pending

## Operation

- Per bank b: set = (bs[b] & on1) | ~allonl; clr = ~roffl[b] | ~alloffl.
- Effective request: set&~clr gives open; clr&~set gives close; set&clr gives toggle, i.e. close if open, open if closed.
- Open request on an open bank, or close on a closed bank: no-op, except it cancels any pending opposite request.
- Per bank state: cs (1 = open), cnt[CW-1:0], pend_open, pend_close.
- Open on closed bank: if cnt==0, cs<=1 and cnt<=TRAS-1; otherwise pend_open<=1.
- Close on open bank: if cnt==0, cs<=0 and cnt<=TRP-1; otherwise pend_close<=1.
- A pending request executes on the first edge where cnt==0, with the same counter load. The pending flag clears on that edge.
- A new request of the opposite kind clears the pending flag. The bank stays in its current state.
- cnt decrements by 1 each edge while non-zero. It saturates at 0.
- csl[b] = ~cs[b]. busy[b] = (cnt!=0) | pend_open | pend_close.

## Timing

- Reset: csl all 1, busy all 0, every counter 0, pending flags clear. Reset takes effect immediately, mid-operation included.
- Latency: a request sampled at edge k changes csl after edge k, so csl moves in cycle k+1.
- A bank opened at edge k cannot close before edge k+TRAS, so csl is low for at least TRAS cycles.
- A bank closed at edge k cannot reopen before edge k+TRP.
- Requests are level-sampled every edge. Holding a request asserted is equivalent to re-issuing it each cycle.
- Toggle (set&clr) held for several cycles toggles on every permitted edge.
- No cross-bank interaction: all-on/all-off evaluate each bank against its own counter.

## Configuration

- RASGEN_TIMING_EN defined: tRAS/tRP guards, counters and pending flags as described.
- RASGEN_TIMING_EN undefined: counters and pending flags are not built, and busy is tied 0. Each bank is a plain JK flop: open, close or toggle takes effect at the next edge, with identical reset behaviour.

## Structure

- Package ras_pkg holds:
  - default constants RAS_NBANK, RAS_TRAS, RAS_TRP, RAS_CW;
  - enum ras_req_t {REQ_NONE, REQ_OPEN, REQ_CLOSE}.
- Sub-module ras_bank implements one bank: request decode, cs, counter and pending flags. ras_bank_gen instantiates NBANK of them in a generate loop and fans out the global inputs.

## Test plan

- Reset release with no requests -> csl=4'b1111, busy=0 indefinitely. Assert resl low while bank 1 is open with pend_close set -> csl[1]=1 and busy[1]=0 immediately.
- bs=4'b0001, on1 pulse at edge 0 -> csl[0]=0 from cycle 1, busy[0]=1 for cycles 1-2 (TRAS=3). roffl[0] low at edge 1 -> pend_close, csl[0] rises after edge 3.
- Close bank 2, then open at the next edge -> open deferred; csl[2] falls after edge 2 (TRP=2), exactly 2 cycles high.
- allonl low one cycle -> all csl 0 next cycle. alloffl low at edge +3 -> all csl 1 the following cycle.
- bs=4'b0100, on1=1 with roffl[2]=0 held 8 cycles -> csl[2] alternates with periods of TRAS low and TRP high.
- Build without RASGEN_TIMING_EN: open at edge 0 and close at edge 1 -> csl low exactly 1 cycle; busy always 0.
